// File: rtl/boot_ctrl_if.sv
//------------------------------------------------------------------------------
// boot_ctrl_if : host loader, CPU memory port and shared memory bus bundle
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface boot_ctrl_if;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [12:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_rvalid;

  logic        cpu_rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_halt;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // Controller side
  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid,
    output cpu_rst_n,
    input  cpu_rd, cpu_wr, cpu_halt, cpu_addr, cpu_wdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: host loader, CPU core and memory
  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid,
    input  cpu_rst_n,
    output cpu_rd, cpu_wr, cpu_halt, cpu_addr, cpu_wdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/boot_ctrl.sv
//------------------------------------------------------------------------------
// boot_ctrl : LOAD/RUN/DONE sequencer owning the CPU reset and memory mux
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module boot_ctrl #(
  parameter int unsigned MAX_CYCLES = 65535,
  parameter int unsigned CNT_W      = 16
) (
  input  wire logic             sys_clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic             abort,
  boot_ctrl_if.slave            bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               timeout_q, timeout_d;
  logic               hwr_q,     hwr_d;
  logic               hrd_q,     hrd_d;
  logic [12:0]        haddr_q,   haddr_d;
  logic [7:0]         hwdata_q,  hwdata_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rvalid_q,  rvalid_d;
  logic [7:0]         rdata_q,   rdata_d;

  logic               run;
  logic               rd_busy;
  logic               host_ready;
  logic               accept;

  assign run        = (state_q == ST_RUN);
  // A read stays in flight from acceptance until the cycle its data is presented
  assign rd_busy    = hrd_q | rd_pend_q;
  assign host_ready = !run && !rd_busy && !start;
  assign accept     = bus.host_valid && host_ready;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      hwr_q     <= 1'b0;
      hrd_q     <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      hwr_q     <= hwr_d;
      hrd_q     <= hrd_d;
      haddr_q   <= haddr_d;
      hwdata_q  <= hwdata_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    hwr_d     = 1'b0;
    hrd_d     = 1'b0;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    // Synchronous memory: data is valid the cycle after the read strobe
    rd_pend_d = hrd_q;
    rvalid_d  = rd_pend_q;
    rdata_d   = rd_pend_q ? bus.mem_rdata : rdata_q;

    unique case (state_q)
      ST_LOAD, ST_DONE: begin
        if (start && !rd_busy) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
        if (accept) begin
          haddr_d  = bus.host_addr;
          hwdata_d = bus.host_wdata;
          hwr_d    = bus.host_we;
          hrd_d    = !bus.host_we;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Halt and abort take priority over the limit so timeout stays clear
        if (bus.cpu_halt || abort) begin
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign bus.host_ready  = host_ready;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.cpu_rst_n   = run;

  assign bus.mem_rd    = run ? bus.cpu_rd    : hrd_q;
  assign bus.mem_wr    = run ? bus.cpu_wr    : hwr_q;
  assign bus.mem_addr  = run ? bus.cpu_addr  : haddr_q;
  assign bus.mem_wdata = run ? bus.cpu_wdata : hwdata_q;

  assign busy      = run;
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;

endmodule

`default_nettype wire
